// File: rtl/cve2_pkg.sv
// Shared definitions for the register-file write-side controller:
// write source encoding, register address width and the RV32E address fold.
package cve2_pkg;

  localparam int unsigned RF_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_EX,
    WB_LSU,
    WB_XIF
  } wb_src_e;

  // RV32E only has 16 registers, so bit 4 of an address is ignored.
  function automatic logic [RF_ADDR_W-1:0] rf_eff_addr(input logic [RF_ADDR_W-1:0] addr,
                                                       input bit rv32e);
    return rv32e ? {1'b0, addr[RF_ADDR_W-2:0]} : addr;
  endfunction

endpackage

// File: rtl/cve2_rf_wb_ctrl_if.sv
// Writeback source bundle: ex result, LSU load response and CV-X-IF result.
// Signal directions are named from the controller's point of view.
interface cve2_rf_wb_ctrl_if #(
  parameter int unsigned DataWidth = 32
);
  import cve2_pkg::*;

  logic                 ex_we_i;
  logic [RF_ADDR_W-1:0] ex_waddr_i;
  logic [DataWidth-1:0] ex_wdata_i;

  logic                 lsu_rvalid_i;
  logic                 lsu_rready_o;
  logic [RF_ADDR_W-1:0] lsu_waddr_i;
  logic [DataWidth-1:0] lsu_wdata_i;

  logic                 xif_valid_i;
  logic                 xif_ready_o;
  logic [RF_ADDR_W-1:0] xif_waddr_i;
  logic [DataWidth-1:0] xif_wdata_i;

  modport master (
    output ex_we_i, ex_waddr_i, ex_wdata_i,
    output lsu_rvalid_i, lsu_waddr_i, lsu_wdata_i,
    output xif_valid_i, xif_waddr_i, xif_wdata_i,
    input  lsu_rready_o, xif_ready_o
  );

  modport slave (
    input  ex_we_i, ex_waddr_i, ex_wdata_i,
    input  lsu_rvalid_i, lsu_waddr_i, lsu_wdata_i,
    input  xif_valid_i, xif_waddr_i, xif_wdata_i,
    output lsu_rready_o, xif_ready_o
  );

endinterface

// File: rtl/cve2_rf_scoreboard.sv
// Pending-destination bit vector for long-latency ops: set on issue, cleared on
// completion, and looked up combinationally by the two read ports.
module cve2_rf_scoreboard
  import cve2_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 set_i,
  input  logic [RF_ADDR_W-1:0] set_addr_i,
  input  logic                 clr_a_i,
  input  logic [RF_ADDR_W-1:0] clr_a_addr_i,
  input  logic                 clr_b_i,
  input  logic [RF_ADDR_W-1:0] clr_b_addr_i,
  input  logic [RF_ADDR_W-1:0] raddr_a_i,
  input  logic [RF_ADDR_W-1:0] raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 empty_o
);

  localparam int unsigned IdxW = $clog2(NUM_WORDS);

  logic [NUM_WORDS-1:0] sb_q, sb_d;
  logic [IdxW-1:0]      set_idx, clr_a_idx, clr_b_idx, rd_a_idx, rd_b_idx;

  assign set_idx   = set_addr_i[IdxW-1:0];
  assign clr_a_idx = clr_a_addr_i[IdxW-1:0];
  assign clr_b_idx = clr_b_addr_i[IdxW-1:0];
  assign rd_a_idx  = raddr_a_i[IdxW-1:0];
  assign rd_b_idx  = raddr_b_i[IdxW-1:0];

  // Set is applied after the clears so a same-cycle reserve wins; x0 is never tracked.
  always_comb begin
    sb_d = sb_q;
    if (clr_a_i) sb_d[clr_a_idx] = 1'b0;
    if (clr_b_i) sb_d[clr_b_idx] = 1'b0;
    if (set_i)   sb_d[set_idx]   = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign hazard_a_o = (rd_a_idx != '0) && sb_q[rd_a_idx];
  assign hazard_b_o = (rd_b_idx != '0) && sb_q[rd_b_idx];
  assign empty_o    = ~|sb_q;

endmodule

// File: rtl/cve2_rf_wb_ctrl.sv
// Owns the register file write port: arbitrates ex/LSU/xif results into one registered
// write, forwards that write to the read ports and reports RAW hazards on pending regs.
module cve2_rf_wb_ctrl
  import cve2_pkg::*;
#(
  parameter bit          RV32E      = 1'b0,
  parameter int unsigned DataWidth  = 32,
  parameter bit          COREV_X_IF = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cve2_rf_wb_ctrl_if.slave     wb_if,
  input  logic                 issue_i,
  input  logic [RF_ADDR_W-1:0] issue_addr_i,
  input  logic [RF_ADDR_W-1:0] raddr_a_i,
  input  logic [RF_ADDR_W-1:0] raddr_b_i,
  input  logic [DataWidth-1:0] rf_rdata_a_i,
  input  logic [DataWidth-1:0] rf_rdata_b_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 rf_we_o,
  output logic [RF_ADDR_W-1:0] rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 idle_o
);

  localparam int unsigned NumWords = RV32E ? 16 : 32;

  logic                 lsu_ready, xif_ready, lsu_hs, xif_hs, sb_empty;
  wb_src_e              win_src;
  logic [RF_ADDR_W-1:0] win_addr;
  logic [DataWidth-1:0] win_data;
  logic [RF_ADDR_W-1:0] raddr_a_eff, raddr_b_eff;

  logic                 rf_we_q, rf_we_d;
  logic [RF_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;

  assign lsu_ready = !wb_if.ex_we_i;
  assign xif_ready = COREV_X_IF && !wb_if.ex_we_i && !wb_if.lsu_rvalid_i;
  assign lsu_hs    = wb_if.lsu_rvalid_i && lsu_ready;
  assign xif_hs    = wb_if.xif_valid_i && xif_ready;

  assign wb_if.lsu_rready_o = lsu_ready;
  assign wb_if.xif_ready_o  = xif_ready;

  // Fixed priority ex > lsu > xif; x0 results are consumed but never written.
  always_comb begin
    win_src    = WB_NONE;
    win_addr   = '0;
    win_data   = '0;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_if.ex_we_i) begin
      win_src = WB_EX;
    end else if (lsu_hs) begin
      win_src = WB_LSU;
    end else if (xif_hs) begin
      win_src = WB_XIF;
    end
    case (win_src)
      WB_EX: begin
        win_addr = rf_eff_addr(wb_if.ex_waddr_i, RV32E);
        win_data = wb_if.ex_wdata_i;
      end
      WB_LSU: begin
        win_addr = rf_eff_addr(wb_if.lsu_waddr_i, RV32E);
        win_data = wb_if.lsu_wdata_i;
      end
      WB_XIF: begin
        win_addr = rf_eff_addr(wb_if.xif_waddr_i, RV32E);
        win_data = wb_if.xif_wdata_i;
      end
      default: ;
    endcase
    if (win_src != WB_NONE && win_addr != '0) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = win_addr;
      rf_wdata_d = win_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;

  cve2_rf_scoreboard #(
    .NUM_WORDS (NumWords)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .set_i        (issue_i),
    .set_addr_i   (rf_eff_addr(issue_addr_i, RV32E)),
    .clr_a_i      (lsu_hs),
    .clr_a_addr_i (rf_eff_addr(wb_if.lsu_waddr_i, RV32E)),
    .clr_b_i      (xif_hs),
    .clr_b_addr_i (rf_eff_addr(wb_if.xif_waddr_i, RV32E)),
    .raddr_a_i    (rf_eff_addr(raddr_a_i, RV32E)),
    .raddr_b_i    (rf_eff_addr(raddr_b_i, RV32E)),
    .hazard_a_o   (hazard_a_o),
    .hazard_b_o   (hazard_b_o),
    .empty_o      (sb_empty)
  );

  // Bypass the registered write until the regfile has committed it.
  assign raddr_a_eff = rf_eff_addr(raddr_a_i, RV32E);
  assign raddr_b_eff = rf_eff_addr(raddr_b_i, RV32E);
  assign rdata_a_o = (rf_we_q && rf_waddr_q == raddr_a_eff && raddr_a_eff != '0) ?
                     rf_wdata_q : rf_rdata_a_i;
  assign rdata_b_o = (rf_we_q && rf_waddr_q == raddr_b_eff && raddr_b_eff != '0) ?
                     rf_wdata_q : rf_rdata_b_i;

  assign idle_o = sb_empty && !rf_we_q;

endmodule
